// File: rtl/fibonacci_checker.sv
// Checks a stream of Fibonacci terms (0,1,1,2,...) against an internal model.
// Define FIB_CHECK_RESYNC_EN to let a sample of 0 restart tracking after a mismatch.
module fibonacci_checker #(
   parameter int unsigned FibBits = 10
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic [FibBits-1:0] f,
   input  logic               f_valid,
   output logic               match,
   output logic               err,
   output logic               done,
   output logic [5:0]         term_cnt,
   output logic [FibBits-1:0] exp_f,
   output logic [FibBits-1:0] bad_f
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] GOT0  = 3'd1;
   localparam logic [2:0] TRACK = 3'd2;
   localparam logic [2:0] ERROR = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

`ifdef FIB_CHECK_RESYNC_EN
   localparam bit ResyncEn = 1'b1;
`else
   localparam bit ResyncEn = 1'b0;
`endif

   localparam logic [FibBits-1:0] One = FibBits'(1);

   logic [2:0]         state_q, state_d;
   logic [FibBits-1:0] prev_q, prev_d;
   logic [FibBits-1:0] last_q, last_d;
   logic [FibBits-1:0] exp_q, exp_d;
   logic [FibBits-1:0] bad_q, bad_d;
   logic               match_q, match_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic [5:0]         cnt_q, cnt_d;

   logic [FibBits:0]   sum;
   logic               accept, mismatch, resync;

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      last_d   = last_q;
      exp_d    = exp_q;
      bad_d    = bad_q;
      match_d  = 1'b0;
      err_d    = err_q;
      done_d   = done_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      mismatch = 1'b0;
      resync   = 1'b0;
      // new prev+last after accepting f in TRACK is last_q+f; the extra bit flags overflow
      sum      = {1'b0, last_q} + {1'b0, f};

      if (f_valid) begin
         case (state_q)
            IDLE: begin
               if (f == '0) begin
                  state_d = GOT0;
                  exp_d   = One;
                  accept  = 1'b1;
               end else begin
                  mismatch = 1'b1;
               end
            end
            GOT0: begin
               if (f == One) begin
                  state_d = TRACK;
                  prev_d  = '0;
                  last_d  = One;
                  exp_d   = One;
                  accept  = 1'b1;
               end else begin
                  mismatch = 1'b1;
               end
            end
            TRACK: begin
               if (f == exp_q) begin
                  prev_d = last_q;
                  last_d = f;
                  exp_d  = sum[FibBits-1:0];
                  accept = 1'b1;
                  if (sum[FibBits]) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end else if (ResyncEn && f == '0) begin
                  resync = 1'b1;
               end else begin
                  mismatch = 1'b1;
               end
            end
            ERROR: begin
               if (ResyncEn && f == '0) begin
                  resync = 1'b1;
               end
            end
            default: ;
         endcase
      end

      if (accept) begin
         match_d = 1'b1;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + 6'd1;
         end
      end

      // bad_f keeps the first offending sample even if tracking later resumes
      if (mismatch) begin
         state_d = ERROR;
         err_d   = 1'b1;
         if (!err_q) begin
            bad_d = f;
         end
      end

      if (resync) begin
         state_d = GOT0;
         prev_d  = '0;
         last_d  = '0;
         exp_d   = One;
         cnt_d   = 6'd1;
         match_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         prev_q  <= '0;
         last_q  <= '0;
         exp_q   <= '0;
         bad_q   <= '0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         last_q  <= last_d;
         exp_q   <= exp_d;
         bad_q   <= bad_d;
         match_q <= match_d;
         err_q   <= err_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign match    = match_q;
   assign err      = err_q;
   assign done     = done_q;
   assign term_cnt = cnt_q;
   assign exp_f    = exp_q;
   assign bad_f    = bad_q;

endmodule
